// File: rtl/rns_reg_file.sv
// Multi-domain RNS register file: 2 combinational reads, 1 lane-masked write,
// busy scoreboard and a sequenced clear sweep. Define REG_FILE_BYPASS_EN for write-to-read forwarding.
module rns_reg_file #(
    parameter int NUM_DOMAINS = 1,
    parameter int DOM_W       = 8,
    parameter int ADDR_W      = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDR_W-1:0]            rd_addr1,
    input  logic [ADDR_W-1:0]            rd_addr2,
    output logic [NUM_DOMAINS*DOM_W-1:0] rd_data1,
    output logic [NUM_DOMAINS*DOM_W-1:0] rd_data2,
    output logic                         rd_busy1,
    output logic                         rd_busy2,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [NUM_DOMAINS*DOM_W-1:0] wr_data,
    input  logic [NUM_DOMAINS-1:0]       wr_dom_mask,
    input  logic                         rsv_en,
    input  logic [ADDR_W-1:0]            rsv_addr,
    input  logic                         clr_req,
    output logic                         clr_busy,
    output logic                         clr_done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int W     = NUM_DOMAINS * DOM_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              done_q, done_d;
    logic [W-1:0]      mem_q [DEPTH];
    logic [W-1:0]      mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;

    logic [W-1:0]      wr_merged;
    logic              wr_ok;
    logic              rsv_ok;

    // Stored word with the enabled lanes replaced; shared by the write path and forwarding.
    always_comb begin
        wr_merged = mem_q[wr_addr];
        for (int d = 0; d < NUM_DOMAINS; d++) begin
            if (wr_dom_mask[d]) begin
                wr_merged[d*DOM_W +: DOM_W] = wr_data[d*DOM_W +: DOM_W];
            end
        end
        wr_ok  = wr_en && (state_q == IDLE);
        rsv_ok = rsv_en && (state_q == IDLE);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        mem_d   = mem_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (wr_ok) begin
                    mem_d[wr_addr]  = wr_merged;
                    busy_d[wr_addr] = 1'b0;
                end
                // Reservation is applied after the write so it wins on a shared address.
                if (rsv_ok) begin
                    busy_d[rsv_addr] = 1'b1;
                end
                if (clr_req) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                mem_d[idx_q]  = '0;
                busy_d[idx_q] = 1'b0;
                idx_d         = idx_q + 1'b1;
                if (idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            mem_q   <= mem_d;
        end
    end

    always_comb begin
        rd_data1 = mem_q[rd_addr1];
        rd_busy1 = busy_q[rd_addr1];
        rd_data2 = mem_q[rd_addr2];
        rd_busy2 = busy_q[rd_addr2];
`ifdef REG_FILE_BYPASS_EN
        // Forwarded busy is the post-edge value: cleared by the write unless reserved alongside it.
        if (wr_ok && (rd_addr1 == wr_addr)) begin
            rd_data1 = wr_merged;
            rd_busy1 = rsv_ok && (rsv_addr == wr_addr);
        end
        if (wr_ok && (rd_addr2 == wr_addr)) begin
            rd_data2 = wr_merged;
            rd_busy2 = rsv_ok && (rsv_addr == wr_addr);
        end
`else
`endif
    end

    assign clr_busy = (state_q == CLEAR);
    assign clr_done = done_q;

endmodule

// File: tb/tb_rns_reg_file.sv
// Self-checking bench for rns_reg_file (NUM_DOMAINS=2, DOM_W=8, ADDR_W=3):
// an array-level reference model checked every cycle plus hand-computed directed checks.
module tb_rns_reg_file;

    localparam int ND    = 2;
    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int W     = ND * DW;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] rd_addr1, rd_addr2, wr_addr, rsv_addr;
    logic [W-1:0]  rd_data1, rd_data2, wr_data;
    logic          rd_busy1, rd_busy2;
    logic          wr_en, rsv_en, clr_req;
    logic [ND-1:0] wr_dom_mask;
    logic          clr_busy, clr_done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] model_mem [DEPTH];
    logic         model_busy [DEPTH];
    int           sweep_idx;
    logic         exp_done;
    logic         check_en = 1'b0;

    rns_reg_file #(.NUM_DOMAINS(ND), .DOM_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_dom_mask(wr_dom_mask),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference model: the spec's rules over a plain array, updated per rising edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                model_mem[i]  = '0;
                model_busy[i] = 1'b0;
            end
            sweep_idx = -1;
            exp_done  = 1'b0;
        end else begin
            exp_done = 1'b0;
            if (sweep_idx >= 0) begin
                model_mem[sweep_idx]  = '0;
                model_busy[sweep_idx] = 1'b0;
                sweep_idx++;
                if (sweep_idx == DEPTH) begin
                    sweep_idx = -1;
                    exp_done  = 1'b1;
                end
            end else begin
                if (wr_en) begin
                    model_mem[wr_addr] = {wr_dom_mask[1] ? wr_data[15:8] : model_mem[wr_addr][15:8],
                                          wr_dom_mask[0] ? wr_data[7:0]  : model_mem[wr_addr][7:0]};
                    model_busy[wr_addr] = 1'b0;
                end
                if (rsv_en) model_busy[rsv_addr] = 1'b1;
                if (clr_req) sweep_idx = 0;
            end
        end
    end

    function automatic logic [W-1:0] exp_data(input logic [AW-1:0] a);
`ifdef REG_FILE_BYPASS_EN
        if (wr_en && sweep_idx < 0 && a == wr_addr)
            return {wr_dom_mask[1] ? wr_data[15:8] : model_mem[a][15:8],
                    wr_dom_mask[0] ? wr_data[7:0]  : model_mem[a][7:0]};
`endif
        return model_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
`ifdef REG_FILE_BYPASS_EN
        if (wr_en && sweep_idx < 0 && a == wr_addr)
            return rsv_en && (rsv_addr == wr_addr);
`endif
        return model_busy[a];
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("cyc_rd_data1", 32'(rd_data1), 32'(exp_data(rd_addr1)));
            checkOutput("cyc_rd_data2", 32'(rd_data2), 32'(exp_data(rd_addr2)));
            checkOutput("cyc_rd_busy1", 32'(rd_busy1), 32'(exp_busy(rd_addr1)));
            checkOutput("cyc_rd_busy2", 32'(rd_busy2), 32'(exp_busy(rd_addr2)));
            checkOutput("cyc_clr_busy", 32'(clr_busy), 32'(sweep_idx >= 0));
            checkOutput("cyc_clr_done", 32'(clr_done), 32'(exp_done));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                                 input logic [ND-1:0] wm, input logic re, input logic [AW-1:0] ra,
                                 input logic cr);
        wr_en = we; wr_addr = wa; wr_data = wd; wr_dom_mask = wm;
        rsv_en = re; rsv_addr = ra; clr_req = cr;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int busy_cycles;
        int done_cnt;
        reset = 1'b1;
        rd_addr1 = '0; rd_addr2 = '0;
        idle();
        tick(); tick();
        reset = 1'b0;
        check_en = 1'b1;

        for (int a = 0; a < DEPTH; a++) begin
            rd_addr1 = AW'(a); rd_addr2 = AW'(DEPTH - 1 - a);
            #1;
            checkOutput("reset_data1", 32'(rd_data1), 32'h0);
            checkOutput("reset_busy2", 32'(rd_busy2), 32'h0);
            tick();
        end
        checkOutput("reset_clr_busy", 32'(clr_busy), 32'h0);

        rd_addr1 = 3'd3; rd_addr2 = 3'd3;
        applyStimulus(1'b1, 3'd3, 16'hA55A, 2'b11, 1'b0, '0, 1'b0);
        tick(); idle(); #1;
        checkOutput("full_write", 32'(rd_data1), 32'h0000A55A);

        applyStimulus(1'b1, 3'd3, 16'h1234, 2'b01, 1'b0, '0, 1'b0);
        tick(); idle(); #1;
        checkOutput("masked_write", 32'(rd_data2), 32'h0000A534);

        rd_addr1 = 3'd5;
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 3'd5, 1'b0);
        tick(); idle(); #1;
        checkOutput("reserve_busy", 32'(rd_busy1), 32'h1);
        applyStimulus(1'b1, 3'd5, 16'h0505, 2'b11, 1'b0, '0, 1'b0);
        tick(); idle(); #1;
        checkOutput("write_clears_busy", 32'(rd_busy1), 32'h0);

        applyStimulus(1'b1, 3'd5, 16'h7777, 2'b11, 1'b1, 3'd5, 1'b0);
        tick(); idle(); #1;
        checkOutput("rsv_wins_busy", 32'(rd_busy1), 32'h1);
        checkOutput("rsv_wins_data", 32'(rd_data1), 32'h00007777);

        rd_addr1 = 3'd1;
        applyStimulus(1'b1, 3'd1, 16'h00FF, 2'b11, 1'b0, '0, 1'b0);
        #1;
`ifdef REG_FILE_BYPASS_EN
        checkOutput("bypass_same_cycle", 32'(rd_data1), 32'h000000FF);
`else
        checkOutput("no_bypass_old", 32'(rd_data1), 32'h0);
`endif
        tick(); idle(); #1;
        checkOutput("bypass_next_cycle", 32'(rd_data1), 32'h000000FF);

        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(1'b1, AW'(a), 16'(16'h1111 * (a + 1)), 2'b11, 1'b0, '0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 3'd2, 1'b0);
        tick(); idle();
        rd_addr1 = 3'd2; rd_addr2 = 3'd0; #1;
        checkOutput("fill_busy2", 32'(rd_busy1), 32'h1);
        checkOutput("fill_data0", 32'(rd_data2), 32'h00001111);

        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
        tick(); idle();
        busy_cycles = 0; done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (clr_busy) busy_cycles++;
            if (clr_done) done_cnt++;
            if (i == 3) applyStimulus(1'b1, 3'd0, 16'hBEEF, 2'b11, 1'b1, 3'd0, 1'b1);
            else idle();
            tick();
        end
        checkOutput("sweep_busy_cycles", 32'(busy_cycles), 32'd8);
        checkOutput("sweep_done_pulses", 32'(done_cnt), 32'd1);
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr1 = AW'(a); #1;
            checkOutput("cleared_data", 32'(rd_data1), 32'h0);
            checkOutput("cleared_busy", 32'(rd_busy1), 32'h0);
            tick();
        end

        applyStimulus(1'b1, 3'd6, 16'h6666, 2'b11, 1'b1, 3'd7, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
        tick(); idle();
        rd_addr1 = 3'd6; rd_addr2 = 3'd7;
        tick(); tick(); tick(); tick();
        #1;
        checkOutput("pre_abort_data6", 32'(rd_data1), 32'h00006666);
        reset = 1'b1;
        #1;
        checkOutput("abort_clr_busy", 32'(clr_busy), 32'h0);
        checkOutput("abort_data6", 32'(rd_data1), 32'h0);
        checkOutput("abort_busy7", 32'(rd_busy2), 32'h0);
        tick();
        reset = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (clr_done) done_cnt++;
            tick();
        end
        checkOutput("abort_no_done", 32'(done_cnt), 32'd0);

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rns_reg_file.md
# rns_reg_file

Parametrised multi-domain register file for the RNS datapath: NUM_DOMAINS residue lanes of DOM_W bits per register, 2**ADDR_W registers, two combinational read ports and one synchronous write port. It adds per-domain write masking, a busy-bit scoreboard for issue-stage hazard checks, and a sequenced clear engine. It sits between decode/issue (reads, reservations) and write-back (writes).

## Interface
- NUM_DOMAINS, 1: residue lanes per register.
- DOM_W, 8: bits per lane.
- ADDR_W, 3: address width; DEPTH = 2**ADDR_W registers.
- Word width W = NUM_DOMAINS*DOM_W.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- rd_addr1  in  ADDR_W  read port 1 address.
- rd_addr2  in  ADDR_W  read port 2 address.
- rd_data1  out  W  read port 1 data.
- rd_data2  out  W  read port 2 data.
- rd_busy1  out  1  scoreboard bit for rd_addr1.
- rd_busy2  out  1  scoreboard bit for rd_addr2.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  W  write data; lane d is bits [d*DOM_W +: DOM_W].
- wr_dom_mask  in  NUM_DOMAINS  per-lane write enable; bit d gates lane d.
- rsv_en  in  1  reserve (set busy) request.
- rsv_addr  in  ADDR_W  register to reserve.
- clr_req  in  1  start clear sweep.
- clr_busy  out  1  high while the sweep runs.
- clr_done  out  1  one-cycle pulse after the final register is cleared.

## Operation
- Reset: all registers = 0, all busy bits = 0, FSM = IDLE, sweep index = 0. Consequently rd_data1/2 = 0, rd_busy1/2 = 0, clr_busy = 0, clr_done = 0.
- Write: on a clock edge with wr_en=1 in IDLE, lane d of reg[wr_addr] takes wr_data lane d iff wr_dom_mask[d]=1; unmasked lanes hold. The busy bit of wr_addr clears on any accepted write, including a write with an all-zero mask.
- Reserve: on a clock edge with rsv_en=1 in IDLE, busy[rsv_addr] is set.
- Same-edge write and reserve to the same address: the reservation wins and busy stays 1. Data is still written.
- Read: rd_data reflects the array at the read address, and rd_busy reflects busy at that address. Both are combinational. Both ports may address the same register.
- Clear FSM:
  - IDLE: clr_req=1 moves to CLEAR with index 0.
  - CLEAR: each cycle, reg[index] is set to 0 (all lanes) and busy[index] to 0, then index increments.
  - When index = DEPTH-1, the FSM returns to IDLE and clr_done pulses on the following cycle.
  - clr_req during CLEAR is ignored.
  - wr_en and rsv_en during CLEAR are dropped. Callers must gate them with clr_busy.
  - Reads during CLEAR return current array contents, so already-cleared entries read 0.
- The index wraps naturally at ADDR_W bits. No out-of-range addresses exist.
- Reset asserted mid-sweep aborts the sweep. The result is the full reset state, and clr_done does not pulse.

## Timing
- Read latency 0: combinational from address to data/busy.
- Write latency 1: data is visible in the array after the rising edge.
- Reservation is visible on rd_busy the cycle after rsv_en.
- clr_busy rises the cycle after clr_req and stays high for exactly DEPTH cycles. clr_done is high on the cycle after clr_busy falls.
- Full sweep from clr_req to clr_done: DEPTH+1 edges.

## Configuration
- REG_FILE_BYPASS_EN defined: write-to-read forwarding is enabled. A read addressing wr_addr while wr_en=1 in IDLE returns the merged value combinationally: new lanes where the mask is set, stored lanes elsewhere. rd_busy for that address shows the post-edge value, which is 0 unless a same-address reservation is present.
- REG_FILE_BYPASS_EN undefined: reads return only stored contents. Read-during-write returns the old value and the pre-edge busy bit.

## Test plan
- Reset then read all 8 registers -> rd_data = 0 and rd_busy = 0 everywhere. With NUM_DOMAINS=2, write reg3 = 16'hA55A, mask 2'b11 -> the next cycle reads 16'hA55A.
- Masked write: reg3 = 16'hA55A, then wr_data 16'h1234 with mask 2'b01 -> reg3 reads 16'hA534.
- Scoreboard, part 1: rsv reg5 -> rd_busy1 = 1 at addr 5 next cycle. Write reg5 -> busy = 0 next cycle.
- Scoreboard, part 2: same-edge rsv and write to reg5 -> busy = 1 and data updated.
- Clear: fill all regs with nonzero values and reserve reg2. Pulse clr_req, then issue a write to reg0 during the sweep -> clr_busy for 8 cycles, clr_done pulses once, all regs 0, busy 0, and the dropped write is not seen.
- Bypass: write reg1 = 16'h00FF while reading addr 1 in the same cycle -> with REG_FILE_BYPASS_EN, reads 16'h00FF that cycle. Without it, reads the old value, then 16'h00FF next cycle.
- Reset mid-sweep: assert reset at sweep cycle 4 -> outputs go to reset state immediately and no clr_done pulse.
